// File: rtl/second_game_logic.sv
// Second-game state engine: player square, falling obstacles, score and game FSM, stepped once per frame.
// Optional build macro SECOND_GAME_SPEEDUP_EN: fall speed rises by 1 each 8 points, capped at 8.
module second_game_logic #(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 600,
  parameter int PLAYER_SIZE   = 20,
  parameter int PLAYER_Y      = 540,
  parameter int PLAYER_STEP   = 4,
  parameter int N_OBST        = 4,
  parameter int OBST_W        = 40,
  parameter int OBST_H        = 20,
  parameter int OBST_SPEED    = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_frame_tick,
  input  logic                             i_start,
  input  logic                             i_btn_left,
  input  logic                             i_btn_right,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_screen_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_screen_y,
  output logic                             o_is_obstacle,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  o_screen_square_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] o_screen_square_y,
  output logic [1:0]                       o_state,
  output logic [9:0]                       o_score
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int CW = $clog2(N_OBST + 1);

  localparam logic [XW:0] C_XL     = (XW+1)'(SCREEN_WIDTH - OBST_W);
  localparam logic [XW:0] C_XMIN   = (XW+1)'(PLAYER_SIZE);
  localparam logic [XW:0] C_XMAX   = (XW+1)'(SCREEN_WIDTH - 1 - PLAYER_SIZE);
  localparam logic [XW:0] C_STEP   = (XW+1)'(PLAYER_STEP);
  localparam logic [XW:0] C_S      = (XW+1)'(PLAYER_SIZE);
  localparam logic [XW:0] C_OWM1   = (XW+1)'(OBST_W - 1);
  localparam logic [XW:0] C_PX0    = (XW+1)'(SCREEN_WIDTH / 2);
  localparam logic [YW:0] C_YMAX   = (YW+1)'(SCREEN_HEIGHT - 1);
  localparam logic [YW:0] C_OHM1   = (YW+1)'(OBST_H - 1);
  localparam logic [YW:0] C_PTOP   = (YW+1)'(PLAYER_Y - PLAYER_SIZE);
  localparam logic [YW:0] C_PBOT   = (YW+1)'(PLAYER_Y + PLAYER_SIZE);
  localparam logic [3:0]  C_SPEED0 = 4'(OBST_SPEED);
  localparam logic [15:0] C_LFSR0  = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [XW-1:0] r_px;
  logic [XW-1:0] r_ox [N_OBST];
  logic [YW-1:0] r_oy [N_OBST];
  logic [9:0]    r_score;
  logic [3:0]    w_speed;

  logic          w_obst_hit;
  logic          w_collide;
  logic [XW-1:0] w_px_next;
  logic [XW-1:0] w_ox_next [N_OBST];
  logic [YW-1:0] w_oy_next [N_OBST];
  logic [CW-1:0] w_wrap_cnt;
  logic [10:0]   w_score_sum;
  logic [9:0]    w_score_next;

  function automatic logic [XW-1:0] f_init_x(input int unsigned i);
    return XW'(i * (SCREEN_WIDTH - OBST_W) / N_OBST);
  endfunction

  function automatic logic [YW-1:0] f_init_y(input int unsigned i);
    return YW'(i * SCREEN_HEIGHT / N_OBST);
  endfunction

  function automatic logic f_covers(input logic [XW-1:0] ox, input logic [YW-1:0] oy,
                                    input logic [XW-1:0] qx, input logic [YW-1:0] qy);
    return ({1'b0, qx} >= {1'b0, ox}) && ({1'b0, qx} <= {1'b0, ox} + C_OWM1) &&
           ({1'b0, qy} >= {1'b0, oy}) && ({1'b0, qy} <= {1'b0, oy} + C_OHM1);
  endfunction

  // Intersection test rearranged so no side goes negative (px-S moved to the other side).
  function automatic logic f_collide(input logic [XW-1:0] ox, input logic [YW-1:0] oy,
                                     input logic [XW-1:0] px);
    return ({1'b0, ox} <= {1'b0, px} + C_S) && ({1'b0, ox} + C_OWM1 + C_S >= {1'b0, px}) &&
           ({1'b0, oy} <= C_PBOT) && ({1'b0, oy} + C_OHM1 >= C_PTOP);
  endfunction

  // Low XW bits of the LFSR rotated right by rot, folded into [0, L).
  function automatic logic [XW-1:0] f_rand_x(input logic [15:0] lfsr, input int unsigned rot);
    logic [XW-1:0] r;
    logic [3:0]    idx;
    for (int unsigned b = 0; b < XW; b++) begin
      idx  = 4'((b + rot) % 16);
      r[b] = lfsr[idx];
    end
    if ({1'b0, r} >= C_XL) return r - C_XL[XW-1:0];
    return r;
  endfunction

  always_comb begin
    w_obst_hit = 1'b0;
    w_collide  = 1'b0;
    for (int unsigned i = 0; i < N_OBST; i++) begin
      w_obst_hit = w_obst_hit | f_covers(r_ox[i], r_oy[i], i_screen_x, i_screen_y);
      w_collide  = w_collide | f_collide(r_ox[i], r_oy[i], r_px);
    end

    w_px_next = r_px;
    if (i_btn_left && !i_btn_right) begin
      w_px_next = ({1'b0, r_px} < C_XMIN + C_STEP) ? C_XMIN[XW-1:0] : r_px - C_STEP[XW-1:0];
    end else if (i_btn_right && !i_btn_left) begin
      w_px_next = ({1'b0, r_px} + C_STEP > C_XMAX) ? C_XMAX[XW-1:0] : r_px + C_STEP[XW-1:0];
    end

    w_wrap_cnt = '0;
    for (int unsigned i = 0; i < N_OBST; i++) begin
      if ({1'b0, r_oy[i]} + (YW+1)'(w_speed) > C_YMAX) begin
        w_oy_next[i] = '0;
        w_ox_next[i] = f_rand_x(r_lfsr, 3 * i);
        w_wrap_cnt   = w_wrap_cnt + CW'(1);
      end else begin
        w_oy_next[i] = r_oy[i] + YW'(w_speed);
        w_ox_next[i] = r_ox[i];
      end
    end

    w_score_sum  = {1'b0, r_score} + 11'(w_wrap_cnt);
    w_score_next = w_score_sum[10] ? '1 : w_score_sum[9:0];
  end

`ifdef SECOND_GAME_SPEEDUP_EN
  logic [3:0] r_speed;
  logic [3:0] w_speed_next;

  assign w_speed = r_speed;

  always_comb begin
    w_speed_next = r_speed;
    if ((w_score_next[9:3] != r_score[9:3]) && (r_speed < 4'd8)) w_speed_next = r_speed + 4'd1;
  end
`else
  assign w_speed = C_SPEED0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= C_LFSR0;
      r_px    <= C_PX0[XW-1:0];
      r_score <= '0;
      for (int unsigned i = 0; i < N_OBST; i++) begin
        r_ox[i] <= f_init_x(i);
        r_oy[i] <= f_init_y(i);
      end
`ifdef SECOND_GAME_SPEEDUP_EN
      r_speed <= C_SPEED0;
`endif
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (i_start) begin
            r_state <= ST_PLAY;
            r_px    <= C_PX0[XW-1:0];
            r_score <= '0;
            for (int unsigned i = 0; i < N_OBST; i++) begin
              r_ox[i] <= f_init_x(i);
              r_oy[i] <= f_init_y(i);
            end
`ifdef SECOND_GAME_SPEEDUP_EN
            r_speed <= C_SPEED0;
`endif
          end
        end
        ST_PLAY: begin
          if (i_frame_tick) begin
            if (w_collide) begin
              r_state <= ST_OVER;
            end else begin
              r_px    <= w_px_next;
              r_score <= w_score_next;
              for (int unsigned i = 0; i < N_OBST; i++) begin
                r_ox[i] <= w_ox_next[i];
                r_oy[i] <= w_oy_next[i];
              end
`ifdef SECOND_GAME_SPEEDUP_EN
              r_speed <= w_speed_next;
`endif
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_is_obstacle     = w_obst_hit;
  assign o_screen_square_x = r_px;
  assign o_screen_square_y = YW'(PLAYER_Y);
  assign o_state           = r_state;
  assign o_score           = r_score;

endmodule

// File: tb/tb_second_game_logic.sv
// Self-checking bench for second_game_logic: directed game scenarios plus random play against a frame-level model.
module tb_second_game_logic;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_frame_tick;
  logic       i_start;
  logic       i_btn_left;
  logic       i_btn_right;
  logic [8:0] i_screen_x;
  logic [9:0] i_screen_y;
  logic       o_is_obstacle;
  logic [8:0] o_screen_square_x;
  logic [9:0] o_screen_square_y;
  logic [1:0] o_state;
  logic [9:0] o_score;

  second_game_logic dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_frame_tick      (i_frame_tick),
    .i_start           (i_start),
    .i_btn_left        (i_btn_left),
    .i_btn_right       (i_btn_right),
    .i_screen_x        (i_screen_x),
    .i_screen_y        (i_screen_y),
    .o_is_obstacle     (o_is_obstacle),
    .o_screen_square_x (o_screen_square_x),
    .o_screen_square_y (o_screen_square_y),
    .o_state           (o_state),
    .o_score           (o_score)
  );

  always #20 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game state as plain integers, advanced one clock at a time.
  int          m_px, m_state, m_score, m_speed;
  int          m_ox [4];
  int          m_oy [4];
  logic [15:0] m_lfsr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_rand_x(input int i);
    int v, s, rot, r;
    v   = int'(m_lfsr);
    s   = 3 * i;
    rot = ((v >> s) | (v << (16 - s))) & 32'hFFFF;
    r   = rot % 512;
    return (r >= 360) ? r - 360 : r;
  endfunction

  function automatic int m_query(input int x, input int y);
    for (int i = 0; i < 4; i++)
      if (x >= m_ox[i] && x <= m_ox[i] + 39 && y >= m_oy[i] && y <= m_oy[i] + 19) return 1;
    return 0;
  endfunction

  task automatic model_reload();
    m_px    = 200;
    m_score = 0;
    m_speed = 2;
    for (int i = 0; i < 4; i++) begin
      m_ox[i] = i * 90;
      m_oy[i] = i * 150;
    end
  endtask

  task automatic model_reset();
    model_reload();
    m_state = 0;
    m_lfsr  = 16'hACE1;
  endtask

  task automatic model_step(input logic st, input logic tk, input logic l, input logic r);
    int hit, wraps, old;
    if (m_state != 1) begin
      if (st) begin
        model_reload();
        m_state = 1;
      end
    end else if (tk) begin
      hit = 0;
      for (int i = 0; i < 4; i++)
        if (m_ox[i] <= m_px + 20 && m_ox[i] + 39 >= m_px - 20 && m_oy[i] <= 560 && m_oy[i] + 19 >= 520)
          hit = 1;
      if (hit != 0) begin
        m_state = 2;
      end else begin
        if (l && !r) m_px = (m_px - 4 < 20) ? 20 : m_px - 4;
        else if (r && !l) m_px = (m_px + 4 > 379) ? 379 : m_px + 4;
        wraps = 0;
        for (int i = 0; i < 4; i++) begin
          if (m_oy[i] + m_speed > 599) begin
            m_oy[i] = 0;
            m_ox[i] = m_rand_x(i);
            wraps++;
          end else begin
            m_oy[i] = m_oy[i] + m_speed;
          end
        end
        old     = m_score;
        m_score = (m_score + wraps > 1023) ? 1023 : m_score + wraps;
`ifdef SECOND_GAME_SPEEDUP_EN
        if (m_score / 8 != old / 8 && m_speed < 8) m_speed++;
`endif
      end
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic probe(input int x, input int y);
    i_screen_x = x[8:0];
    i_screen_y = y[9:0];
    #1;
    check("query", o_is_obstacle, m_query(x, y));
  endtask

  task automatic probe_all();
    for (int i = 0; i < 4; i++) begin
      probe(m_ox[i], m_oy[i]);
      probe(m_ox[i] + 39, m_oy[i] + 19);
      probe(m_ox[i] + 40, m_oy[i]);
      if (m_oy[i] > 0) probe(m_ox[i], m_oy[i] - 1);
    end
    probe($urandom_range(0, 399), $urandom_range(0, 599));
    probe($urandom_range(0, 399), $urandom_range(0, 599));
  endtask

  task automatic step(input logic st, input logic tk, input logic l, input logic r);
    i_start      = st;
    i_frame_tick = tk;
    i_btn_left   = l;
    i_btn_right  = r;
    @(posedge i_clk);
    model_step(st, tk, l, r);
    #1;
    i_start      = 1'b0;
    i_frame_tick = 1'b0;
    check("state", o_state, m_state);
    check("score", o_score, m_score);
    check("px", o_screen_square_x, m_px);
    if (st || tk) probe_all();
  endtask

  task automatic frame(input logic l, input logic r, input logic st);
    step(st, 1'b1, l, r);
    step(1'b0, 1'b0, l, r);
    step(1'b0, 1'b0, l, r);
  endtask

  task automatic do_reset();
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_state", o_state, 0);
    check("rst_score", o_score, 0);
    check("rst_px", o_screen_square_x, 200);
    check("rst_py", o_screen_square_y, 540);
    @(posedge i_clk);
    #5 i_rst_n = 1'b1;
  endtask

  initial begin
    logic l, r;
    i_rst_n      = 1'b0;
    i_frame_tick = 1'b0;
    i_start      = 1'b0;
    i_btn_left   = 1'b0;
    i_btn_right  = 1'b0;
    i_screen_x   = '0;
    i_screen_y   = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #5;
    check("rst_state", o_state, 0);
    check("rst_score", o_score, 0);
    check("rst_px", o_screen_square_x, 200);
    check("rst_py", o_screen_square_y, 540);
    i_screen_x = 9'd275; i_screen_y = 10'd455; #1;
    check("rst_q_in", o_is_obstacle, 1);
    i_screen_x = 9'd50;  i_screen_y = 10'd455; #1;
    check("rst_q_out", o_is_obstacle, 0);
    i_rst_n = 1'b1;

    repeat (5) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("idle_state", o_state, 0);

    // No buttons from start: obstacle 3 wraps on tick 75, obstacle 2 hits the player on tick 102.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 102; k++) begin
      frame(1'b0, 1'b0, 1'b0);
      if (k == 74)  check("pre_wrap_score", o_score, 0);
      if (k == 75)  check("wrap_score", o_score, 1);
      if (k == 101) check("pre_coll_state", o_state, 1);
    end
    check("over_state", o_state, 2);
    check("over_score", o_score, 1);

    repeat (3) frame(1'b1, 1'b0, 1'b0);
    check("frozen_px", o_screen_square_x, 200);
    check("frozen_state", o_state, 2);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_state", o_state, 1);
    check("restart_score", o_score, 0);
    check("restart_px", o_screen_square_x, 200);
    i_screen_x = 9'd275; i_screen_y = 10'd455; #1;
    check("restart_q", o_is_obstacle, 1);

    frame(1'b0, 1'b1, 1'b0);
    check("right_one", o_screen_square_x, 204);
    repeat (50) frame(1'b1, 1'b0, 1'b0);
    check("left_sat", o_screen_square_x, 20);
    repeat (3) frame(1'b1, 1'b1, 1'b0);
    check("both_btn", o_screen_square_x, 20);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_in_play", o_state, 1);

    do_reset();

    l = 1'b0;
    r = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 15) == 0) {l, r} = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) == 0), l, r);
      if (n == 1200) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
